// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the fetch-path PC / branch-target adder.
package pipelined_adder_pkg;

  localparam int XLEN      = 32;
  localparam int PC_STEP   = 4;
  localparam int PC_STEP_C = 2;

  typedef enum logic [1:0] {
    ADD      = 2'b00,
    ADD_INC  = 2'b01,
    SUB      = 2'b10,
    ADD_INC2 = 2'b11
  } mode_e;

endpackage

// File: rtl/pipe_stage_ctl.sv
// Valid bit and load control for one pipeline stage; combinational load, no added latency.
// A stage loads when empty or when its contents leave this cycle, so bubbles collapse.
module pipe_stage_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic i_up_vld,
  input  logic i_down_ld,
  output logic o_vld,
  output logic o_load
);

  logic r_vld;

  assign o_load = !r_vld || i_down_ld;
  assign o_vld  = r_vld;

  // Loading with an invalid predecessor empties the stage once its data has left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (o_load) begin
      r_vld <= i_up_vld;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Two-stage multi-mode adder (add / +INC / sub / +INC2) with carry, overflow, zero flags.
// Latency 2, throughput 1; valid/ready both sides, in_ready drops only when both stages are full and stalled.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int LO_W  = WIDTH / 2,
  parameter int INC   = PC_STEP,
  parameter int INC2  = PC_STEP_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int HI_W = WIDTH - LO_W;

  logic             w_s1_vld;
  logic             w_s1_ld;
  logic             w_s2_vld;
  logic             w_s2_ld;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [LO_W:0]    w_lo_sum;
  logic [HI_W:0]    w_hi_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  logic [LO_W-1:0]  r_sum_lo;
  logic             r_c_lo;
  logic [HI_W-1:0]  r_a_hi;
  logic [HI_W-1:0]  r_b_hi;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  pipe_stage_ctl u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_up_vld  (w_s1_vld),
    .i_down_ld (out_ready),
    .o_vld     (w_s2_vld),
    .o_load    (w_s2_ld)
  );

  pipe_stage_ctl u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_up_vld  (in_valid),
    .i_down_ld (w_s2_ld),
    .o_vld     (w_s1_vld),
    .o_load    (w_s1_ld)
  );

  assign in_ready  = w_s1_ld;
  assign out_valid = w_s2_vld;

  // Subtraction is A + ~B + 1 so one carry chain serves every mode.
  always_comb begin
    w_b   = in2;
    w_cin = 1'b0;
    case (mode_e'(sel))
      ADD:      w_b = in2;
      ADD_INC:  w_b = WIDTH'(INC);
      SUB: begin
        w_b   = ~in2;
        w_cin = 1'b1;
      end
      ADD_INC2: w_b = WIDTH'(INC2);
      default:  w_b = in2;
    endcase
  end

  assign w_lo_sum = {1'b0, in1[LO_W-1:0]} + {1'b0, w_b[LO_W-1:0]} + {{LO_W{1'b0}}, w_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_lo <= '0;
      r_c_lo   <= 1'b0;
      r_a_hi   <= '0;
      r_b_hi   <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else if (w_s1_ld && in_valid) begin
      r_sum_lo <= w_lo_sum[LO_W-1:0];
      r_c_lo   <= w_lo_sum[LO_W];
      r_a_hi   <= in1[WIDTH-1:LO_W];
      r_b_hi   <= w_b[WIDTH-1:LO_W];
      r_a_msb  <= in1[WIDTH-1];
      r_b_msb  <= w_b[WIDTH-1];
    end
  end

  assign w_hi_sum = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{HI_W{1'b0}}, r_c_lo};
  assign w_res    = {w_hi_sum[HI_W-1:0], r_sum_lo};
  assign w_ovf    = (r_a_msb == r_b_msb) && (w_res[WIDTH-1] != r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_s2_ld && w_s1_vld) begin
      r_out   <= w_res;
      r_carry <= w_hi_sum[HI_W];
      r_ovf   <= w_ovf;
      r_zero  <= (w_res == '0);
    end
  end

  assign out   = r_out;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign zero  = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a full-width reference model predicts each accepted operation.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [1:0]  sel = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        carry;
  logic        ovf;
  logic        zero;

  logic rdy_man = 1'b1;
  logic rnd_rdy = 1'b1;
  logic rand_bp = 1'b0;
  logic chk_lat = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] out;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [31:0] snap;

  assign out_ready = rand_bp ? rnd_rdy : rdy_man;

  pipelined_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    exp_t        r;
    logic [31:0] bb;
    logic        cin;
    logic [32:0] full;
    cin = 1'b0;
    case (s)
      2'b00: bb = b;
      2'b01: bb = 32'd4;
      2'b10: begin bb = ~b; cin = 1'b1; end
      default: bb = 32'd2;
    endcase
    full  = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
    r.out = full[31:0];
    r.c   = full[32];
    r.v   = (a[31] == bb[31]) && (full[31] != a[31]);
    r.z   = (full[31:0] == 32'd0);
    r.acc = 0;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input bit must_rdy);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    sel = s;
    #1;
    if (must_rdy) chk("stream_in_ready", in_ready, 1);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e     = model(a, b, s);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in1 = $urandom;
      in2 = $urandom;
      sel = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("out", out, m_e.out);
        chk("carry", carry, m_e.c);
        chk("ovf", ovf, m_e.v);
        chk("zero", zero, m_e.z);
        if (chk_lat) chk("latency", 64'(cyc - m_e.acc), 2);
      end
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {carry, ovf, zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Single add with explicit timing of out_valid
    chk_lat = 1'b1;
    send(32'd20, 32'd30, 2'b00, 1'b0);
    #1 chk("single_not_early", out_valid, 0);
    @(negedge clk);
    #1 chk("single_valid", out_valid, 1);
    @(negedge clk);
    #1 chk("single_one_cycle", out_valid, 0);
    @(negedge clk);

    // Wrap-around, compressed step, subtract flags
    send(32'hFFFF_FFFC, 32'hDEAD_BEEF, 2'b01, 1'b0);
    send(32'd10, 32'h1234_5678, 2'b11, 1'b0);
    send(32'd5, 32'd7, 2'b10, 1'b0);
    send(32'h8000_0000, 32'd1, 2'b10, 1'b0);
    send(32'd9, 32'd9, 2'b10, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
    idle(4);
    drain();

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) send(32'(i), 32'(100 * i), 2'b00, 1'b1);
    idle(4);
    drain();
    chk_lat = 1'b0;

    // Backpressure: two accepts then full stall
    rdy_man = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in1 = 32'(1000 + i);
      in2 = 32'(7 * i);
      sel = 2'b00;
      #1 chk("bp_accept_rdy", in_ready, 1);
      m_e = model(in1, in2, sel);
      sb.push_back(m_e);
      @(negedge clk);
    end
    in1 = 32'd1002;
    in2 = 32'd14;
    #1;
    chk("bp_stall_rdy0", in_ready, 0);
    chk("bp_stall_vld", out_valid, 1);
    snap = out;
    @(negedge clk);
    #1;
    chk("bp_stall_rdy1", in_ready, 0);
    chk("bp_hold_out", out, snap);
    @(negedge clk);
    #1 chk("bp_hold_out2", out, snap);
    @(negedge clk);
    rdy_man = 1'b1;
    send(32'd1002, 32'd14, 2'b00, 1'b0);
    send(32'd1003, 32'd21, 2'b10, 1'b0);
    send(32'd1004, 32'd28, 2'b01, 1'b0);
    idle(3);
    drain();

    // Random traffic under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    drain();
    rand_bp = 1'b0;

    // Reset with both stages full
    rdy_man = 1'b0;
    send(32'd111, 32'd222, 2'b00, 1'b0);
    send(32'd333, 32'd444, 2'b00, 1'b0);
    #1 chk("pre_reset_full", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst_in_ready", in_ready, 1);
    rdy_man = 1'b1;
    chk_lat = 1'b1;
    send(32'd1, 32'd1, 2'b00, 1'b0);
    idle(4);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
